// File: rtl/xbar_rr_arbiter_pkg.sv
// Shared constants and types for the crossbar round-robin arbiter.
// Bus field widths, FSM state encoding and the default watchdog limit.
package xbar_rr_arbiter_pkg;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int WR_W        = 4;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/xbar_rr_arbiter_if.sv
// Bundle of master-side request/response and slave-side forwarded signals.
// The arbiter uses the slave modport; the environment drives through the master modport.
interface xbar_rr_arbiter_if #(
    parameter int NMASTERS = 3
);
    import xbar_rr_arbiter_pkg::*;

    logic [ADDR_W*NMASTERS-1:0] master_address;
    logic [DATA_W*NMASTERS-1:0] master_data_i;
    logic [WR_W*NMASTERS-1:0]   master_wr;
    logic [NMASTERS-1:0]        master_enable;
    logic [DATA_W-1:0]          master_data_o;
    logic [NMASTERS-1:0]        master_ready;
    logic [NMASTERS-1:0]        master_error;

    logic [ADDR_W-1:0]          slave_address;
    logic [DATA_W-1:0]          slave_data_o;
    logic [WR_W-1:0]            slave_wr;
    logic                       slave_enable;
    logic [DATA_W-1:0]          slave_data_i;
    logic                       slave_ready;
    logic                       slave_error;

    modport slave (
        input  master_address, master_data_i, master_wr, master_enable,
        input  slave_data_i, slave_ready, slave_error,
        output master_data_o, master_ready, master_error,
        output slave_address, slave_data_o, slave_wr, slave_enable
    );

    modport master (
        output master_address, master_data_i, master_wr, master_enable,
        output slave_data_i, slave_ready, slave_error,
        input  master_data_o, master_ready, master_error,
        input  slave_address, slave_data_o, slave_wr, slave_enable
    );

endinterface

// File: rtl/xbar_rr_arbiter_rr_pick.sv
// Round-robin picker: first requester scanning upward from last+1 (mod N).
// Latency: purely combinational.
// Backpressure: none; vld low when no request is present.
module rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    int               sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        vld  = 1'b0;
        sum  = 0;
        cand = '0;
        // last itself is visited last, so a repeat requester yields to others
        for (int i = 1; i <= N; i++) begin
            sum = int'(last) + i;
            if (sum >= N) begin
                sum = sum - N;
            end
            cand = IDX_W'(sum);
            if (!vld && req[cand]) begin
                vld       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/xbar_rr_arbiter.sv
// Round-robin arbiter sharing one crossbar slave port, with a per-transaction watchdog.
// Latency: one IDLE cycle to grant, then slave response forwarded in the same cycle.
// Backpressure: requests are held until ready/error; watchdog forces an error after TIMEOUT_CYCLES.
module xbar_rr_arbiter
    import xbar_rr_arbiter_pkg::*;
#(
    parameter int NMASTERS       = 3,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                clk,
    input  logic                rst,
    xbar_rr_arbiter_if.slave    bus,
    output logic [NMASTERS-1:0] grant,
    output logic                timeout_evt
);

    localparam int IDX_W = $clog2(NMASTERS);

    state_e                 state_q, state_d;
    logic [NMASTERS-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic [NMASTERS-1:0]    pick_gnt;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_vld;
    logic                   en_g;
    logic                   expire;
    logic                   hit;

    rr_pick #(
        .N     (NMASTERS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req  (bus.master_enable),
        .last (last_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .vld  (pick_vld)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NMASTERS - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // AND-OR mux on the registered one-hot grant; all zero while idle
    always_comb begin
        bus.slave_address = '0;
        bus.slave_data_o  = '0;
        bus.slave_wr      = '0;
        for (int i = 0; i < NMASTERS; i++) begin
            if (grant_q[i]) begin
                bus.slave_address = bus.slave_address | bus.master_address[i*ADDR_W +: ADDR_W];
                bus.slave_data_o  = bus.slave_data_o  | bus.master_data_i[i*DATA_W +: DATA_W];
                bus.slave_wr      = bus.slave_wr      | bus.master_wr[i*WR_W +: WR_W];
            end
        end
    end

    assign en_g   = |(bus.master_enable & grant_q);
    assign expire = (cnt_q >= CNT_WIDTH'(TIMEOUT_CYCLES - 1));
    assign grant  = grant_q;

    always_comb begin
        state_d           = state_q;
        grant_d           = grant_q;
        last_d            = last_q;
        cnt_d             = cnt_q;
        hit               = 1'b0;
        timeout_evt       = 1'b0;
        bus.slave_enable  = 1'b0;
        bus.master_ready  = '0;
        bus.master_error  = '0;
        bus.master_data_o = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d = ST_BUSY;
                    grant_d = pick_gnt;
                    last_d  = pick_idx;
                    cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                bus.master_data_o = bus.slave_data_i;
                if (!en_g) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end else begin
                    // a real slave response in the expiry cycle beats the watchdog
                    hit              = bus.slave_ready | bus.slave_error;
                    timeout_evt      = expire & ~hit;
                    bus.slave_enable = ~timeout_evt;
                    if (bus.slave_ready) begin
                        bus.master_ready = grant_q;
                    end
                    if (bus.slave_error || timeout_evt) begin
                        bus.master_error = grant_q;
                    end
                    if (hit || expire) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        cnt_d   = '0;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_xbar_rr_arbiter.sv
// Scenario bench for xbar_rr_arbiter: expected completions queued at request time,
// matched against ready/error pulses sampled on the falling edge.
module tb_xbar_rr_arbiter;
    import xbar_rr_arbiter_pkg::*;

    localparam int NM  = 3;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [NM-1:0] grant;
    logic          timeout_evt;

    xbar_rr_arbiter_if #(.NMASTERS(NM)) bus ();

    xbar_rr_arbiter #(
        .NMASTERS       (NM),
        .TIMEOUT_CYCLES (TMO),
        .CNT_WIDTH      (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .grant       (grant),
        .timeout_evt (timeout_evt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NM-1:0] rdy;
        logic [NM-1:0] err;
        logic          tmo;
        logic [31:0]   data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [NM-1:0] s_grant, s_rdy, s_err;
    logic          s_tmo, s_sen;
    logic [31:0]   s_addr, s_wdat, s_mdo;
    logic [3:0]    s_wr;

    task automatic drive_idle();
        bus.master_address = '0;
        bus.master_data_i  = '0;
        bus.master_wr      = '0;
        bus.master_enable  = '0;
        bus.slave_data_i   = '0;
        bus.slave_ready    = 1'b0;
        bus.slave_error    = 1'b0;
    endtask

    task automatic set_master(input int m, input logic en, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [3:0] wr);
        bus.master_enable[m]               = en;
        bus.master_address[m*ADDR_W +: ADDR_W] = addr;
        bus.master_data_i[m*DATA_W +: DATA_W]  = wd;
        bus.master_wr[m*WR_W +: WR_W]          = wr;
    endtask

    task automatic expect_txn(input logic [NM-1:0] rdy, input logic [NM-1:0] err,
                              input logic tmo, input logic [31:0] data);
        exp_t e;
        e.rdy  = rdy;
        e.err  = err;
        e.tmo  = tmo;
        e.data = data;
        sb.push_back(e);
    endtask

    // One bus cycle: sample at negedge, score any pulse, return just after posedge
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        s_grant = grant;
        s_rdy   = bus.master_ready;
        s_err   = bus.master_error;
        s_tmo   = timeout_evt;
        s_sen   = bus.slave_enable;
        s_addr  = bus.slave_address;
        s_wdat  = bus.slave_data_o;
        s_wr    = bus.slave_wr;
        s_mdo   = bus.master_data_o;
        if (s_grant == '0) begin
            checks++;
            if (s_mdo !== 32'h0) begin
                errors++;
                $display("FAIL idle_data master_data_o=%h expected 0", s_mdo);
            end
        end
        if (|s_rdy || |s_err) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse ready=%b error=%b expected none", s_rdy, s_err);
            end else begin
                e = sb.pop_front();
                if (s_rdy !== e.rdy || s_err !== e.err || s_tmo !== e.tmo ||
                    (|e.rdy && s_mdo !== e.data)) begin
                    errors++;
                    $display("FAIL completion ready=%b error=%b tmo=%b data=%h expected ready=%b error=%b tmo=%b data=%h",
                             s_rdy, s_err, s_tmo, s_mdo, e.rdy, e.err, e.tmo, e.data);
                end
            end
        end else begin
            checks++;
            if (s_tmo !== 1'b0) begin
                errors++;
                $display("FAIL stray_timeout timeout_evt=%b expected 0", s_tmo);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        bus.slave_data_i = 32'hFFFF_FFFF;
        rst = 1'b0;
        #12;
        checks++;
        if (grant !== '0 || bus.slave_enable !== 1'b0 || timeout_evt !== 1'b0 ||
            bus.master_data_o !== 32'h0 || bus.master_ready !== '0 || bus.master_error !== '0) begin
            errors++;
            $display("FAIL reset_state grant=%b sen=%b tmo=%b mdo=%h expected all 0",
                     grant, bus.slave_enable, timeout_evt, bus.master_data_o);
        end
        do_reset();
    endtask

    task automatic test_single_read();
        set_master(1, 1'b1, 32'h1000_0004, 32'h0, 4'h0);
        expect_txn(3'b010, 3'b000, 1'b0, 32'hA5A5_0001);
        cyc();
        for (int b = 1; b <= 3; b++) begin
            if (b == 3) begin
                bus.slave_ready  = 1'b1;
                bus.slave_data_i = 32'hA5A5_0001;
            end
            cyc();
            checks++;
            if (s_grant !== 3'b010 || s_sen !== 1'b1 || s_addr !== 32'h1000_0004 || s_wr !== 4'h0) begin
                errors++;
                $display("FAIL read_busy%0d grant=%b sen=%b addr=%h wr=%h expected 010 1 10000004 0",
                         b, s_grant, s_sen, s_addr, s_wr);
            end
        end
        drive_idle();
        cyc();
        checks++;
        if (s_grant !== '0) begin
            errors++;
            $display("FAIL read_idle grant=%b expected 000", s_grant);
        end
    endtask

    task automatic test_round_robin();
        logic [NM-1:0] g;
        do_reset();
        for (int m = 0; m < NM; m++) begin
            set_master(m, 1'b1, 32'h100 * m, 32'h0, 4'h0);
        end
        bus.slave_ready  = 1'b1;
        bus.slave_data_i = 32'hCAFE_0000;
        for (int t = 0; t < 6; t++) begin
            g = NM'(1) << (t % NM);
            expect_txn(g, 3'b000, 1'b0, 32'hCAFE_0000);
            cyc();
            cyc();
            checks++;
            if (s_grant !== g || s_addr !== 32'h100 * (t % NM)) begin
                errors++;
                $display("FAIL rr_order%0d grant=%b addr=%h expected %b %h",
                         t, s_grant, s_addr, g, 32'h100 * (t % NM));
            end
        end
        drive_idle();
        cyc();
    endtask

    task automatic test_timeout();
        set_master(2, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        expect_txn(3'b000, 3'b100, 1'b1, 32'h0);
        cyc();
        for (int b = 1; b <= TMO; b++) begin
            cyc();
            checks++;
            if (s_grant !== 3'b100 || s_sen !== (b < TMO) ||
                (b == 1 && (s_addr !== 32'h10 || s_wr !== 4'hF || s_wdat !== 32'hDEAD_BEEF))) begin
                errors++;
                $display("FAIL timeout_busy%0d grant=%b sen=%b addr=%h wr=%h wdat=%h",
                         b, s_grant, s_sen, s_addr, s_wr, s_wdat);
            end
        end
        drive_idle();
        cyc();
        checks++;
        if (s_grant !== '0) begin
            errors++;
            $display("FAIL timeout_idle grant=%b expected 000", s_grant);
        end
    endtask

    task automatic test_slave_error();
        set_master(0, 1'b1, 32'h2000_0000, 32'h0, 4'h0);
        expect_txn(3'b000, 3'b001, 1'b0, 32'h0);
        cyc();
        bus.slave_error = 1'b1;
        cyc();
        checks++;
        if (s_grant !== 3'b001) begin
            errors++;
            $display("FAIL err_grant grant=%b expected 001", s_grant);
        end
        drive_idle();
        cyc();
        set_master(0, 1'b1, 32'h2000_0008, 32'h0, 4'h0);
        expect_txn(3'b001, 3'b000, 1'b0, 32'h1234_5678);
        cyc();
        bus.slave_ready  = 1'b1;
        bus.slave_data_i = 32'h1234_5678;
        cyc();
        checks++;
        if (s_grant !== 3'b001 || s_addr !== 32'h2000_0008) begin
            errors++;
            $display("FAIL err_recover grant=%b addr=%h expected 001 20000008", s_grant, s_addr);
        end
        drive_idle();
        cyc();
    endtask

    task automatic test_abort();
        set_master(1, 1'b1, 32'h4000_0000, 32'h0, 4'h3);
        cyc();
        for (int b = 1; b <= 2; b++) begin
            cyc();
            checks++;
            if (s_grant !== 3'b010 || s_sen !== 1'b1) begin
                errors++;
                $display("FAIL abort_busy%0d grant=%b sen=%b expected 010 1", b, s_grant, s_sen);
            end
        end
        set_master(1, 1'b0, 32'h4000_0000, 32'h0, 4'h3);
        bus.slave_ready  = 1'b1;
        bus.slave_data_i = 32'h5555_5555;
        cyc();
        checks++;
        if (s_sen !== 1'b0 || s_grant !== 3'b010) begin
            errors++;
            $display("FAIL abort_cycle sen=%b grant=%b expected 0 010", s_sen, s_grant);
        end
        drive_idle();
        cyc();
        checks++;
        if (s_grant !== '0) begin
            errors++;
            $display("FAIL abort_idle grant=%b expected 000", s_grant);
        end
    endtask

    task automatic test_async_reset();
        set_master(2, 1'b1, 32'h3000_0000, 32'h0, 4'h0);
        bus.slave_data_i = 32'h7777_7777;
        cyc();
        cyc();
        checks++;
        if (s_grant !== 3'b100) begin
            errors++;
            $display("FAIL arst_pre grant=%b expected 100", s_grant);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (grant !== '0 || bus.slave_enable !== 1'b0 || bus.slave_address !== 32'h0 ||
            bus.master_data_o !== 32'h0 || timeout_evt !== 1'b0) begin
            errors++;
            $display("FAIL arst_outputs grant=%b sen=%b addr=%h mdo=%h tmo=%b expected all 0",
                     grant, bus.slave_enable, bus.slave_address, bus.master_data_o, timeout_evt);
        end
        set_master(0, 1'b1, 32'h5000_0000, 32'h0, 4'h0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        expect_txn(3'b001, 3'b000, 1'b0, 32'h7777_7777);
        bus.slave_ready = 1'b1;
        cyc();
        checks++;
        if (s_grant !== 3'b001 || s_addr !== 32'h5000_0000) begin
            errors++;
            $display("FAIL arst_priority grant=%b addr=%h expected 001 50000000", s_grant, s_addr);
        end
        drive_idle();
        cyc();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_timeout();
        test_slave_error();
        test_abort();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout run exceeded time limit");
        $fatal(1);
    end

endmodule
